mdio_master: RTL and testbench
==============================

# mdio_master

Parametrised MDIO management-station controller: serialises one 32-bit management frame per request onto MDC/MDIO. It has a configurable MDC divider and preamble length, supports Clause 22 and Clause 45 framing, checks the read turnaround, and has an explicit busy/done handshake. It sits between the register-access logic (T_DATA/MDIO_START/RD_DATA) and the PHY-facing tristate pad (MDC, MDIO_OUT, MDIO_OE, MDIO_IN).

## Interface
- CLK_DIV, 4: clk cycles per MDC half-period (≥1); MDC period = 2·CLK_DIV clk.
- PRE_LEN, 32: preamble bits (all ones) before ST; 0 = preamble suppression.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- MDIO_START  in  1  request; sampled only in IDLE.
- T_DATA  in  32  frame {ST[31:30], OP[29:28], PHYAD[27:23], REGAD[22:18], TA[17:16], DATA[15:0]}; latched on accepted start.
- MDIO_IN  in  1  serial data from pad.
- RD_DATA  out  16  last read data; reset 0.
- DATA_RDY  out  1  one-cycle completion pulse, every transaction; reset 0.
- RD_ERR  out  1  read TA error, valid with DATA_RDY, held until next accepted start; reset 0.
- BUSY  out  1  high from the cycle after accept until the DATA_RDY cycle inclusive; reset 0.
- MDC  out  1  management clock; low when idle; reset 0.
- MDIO_OE  out  1  pad drive enable; reset 0.
- MDIO_OUT  out  1  pad data; reset 1.

## Operation
- States: IDLE → PRE (if PRE_LEN>0) → HDR (14 bits ST..REGAD) → TA (2 bits) → DAT (16 bits) → DONE → IDLE.
- Read decode from latched frame: ST=01 & OP=10 (C22 read), or ST=00 & OP∈{11,10} (C45 read / post-read-increment). All else is a write-type frame (C22 write, C45 address/write).
- PRE/HDR: OE=1, MDIO_OUT = 1 for preamble, then frame bits MSB first.
- Write-type: TA and DAT driven from T_DATA[17:0], OE=1 throughout.
- Read: OE drops to 0 at the start of TA bit 0 and stays 0 through DAT. MDIO_IN is sampled at TA bit 1 (must be 0, else RD_ERR=1). 16 DAT bits are shifted in MSB first. RD_DATA is updated in the DONE cycle, even on error.
- Write-type completion leaves RD_DATA unchanged and RD_ERR=0.
- DONE: DATA_RDY=1 for one cycle, OE=0, MDIO_OUT=1, MDC=0; next state IDLE.
- MDIO_START while BUSY or in DONE: ignored (no queueing).

## Timing
- Accept edge t0: MDIO_START=1 in IDLE; T_DATA latched at t0, RD_ERR cleared at t0.
- Bit k (k=0..PRE_LEN+31) occupies clk cycles t0+1+2·CLK_DIV·k … +2·CLK_DIV−1. MDC is low in the first CLK_DIV cycles of each bit, high in the rest.
- MDIO_OUT/MDIO_OE change only in the first cycle of a bit (MDC falling/low phase); stable across the MDC rising edge.
- MDIO_IN is registered in the cycle MDC goes 1 (mid-bit).
- DATA_RDY asserted at cycle t0 + 2·CLK_DIV·(PRE_LEN+32) + 1. The earliest next accept is the cycle after.
- rst=0 at any edge, including mid-frame: all outputs take their reset values at that edge, FSM → IDLE, partial shift data discarded, no DATA_RDY.
- Simultaneous rst=0 and MDIO_START=1: reset wins.
- CLK_DIV counter and bit counter wrap only at their terminal values. Bit counter width is clog2(PRE_LEN+33).

## Structure
- Package mdio_pkg: state enum; frame field positions; ST_C22=2'b01, ST_C45=2'b00; OP codes (C22 RD/WR, C45 ADDR/WR/RD/RDINC); read-decode function.
- Sub-module mdio_clkgen (param CLK_DIV): generates MDC, rise_tick, fall_tick. Held in reset and low while the FSM is in IDLE/DONE.
- mdio_master: FSM, 32-bit TX shift reg, 16-bit RX shift reg, bit counter.

## Test plan
- Reset: hold rst=0 4 cycles with MDIO_START=1 → MDC=0, OE=0, MDIO_OUT=1, BUSY=0, DATA_RDY never set.
- C22 write, CLK_DIV=2, PRE_LEN=0, T_DATA=32'h5A5AFF01 → MDIO_OUT bit-serial equals 5A5AFF01 MSB first, OE=1 all 32 bits, DATA_RDY at t0+129, RD_DATA unchanged.
- C22 read, T_DATA=32'h6A5A0000, PHY model drives TA bit1=0 then 16'h8FF1 → OE=0 for last 18 bits, RD_DATA=16'h8FF1, RD_ERR=0.
- TA error: same read, MDIO_IN held 1 → RD_ERR=1 with DATA_RDY, RD_DATA=16'hFFFF; next start clears RD_ERR.
- C45: T_DATA=32'h0A5A1234 (address) → OE=1 all bits. Then 32'h3A5A0000 (read) with PHY data 16'hBEEF → RD_DATA=16'hBEEF.
- Defaults (CLK_DIV=4, PRE_LEN=32): 32 MDC periods of MDIO_OUT=1 precede ST. A second MDIO_START mid-frame is ignored. rst=0 at bit 40 → immediate idle, no DATA_RDY, and a new start then completes normally at t0+513.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared types and frame constants for the MDIO management-station controller.
package mdio_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_TA,
        S_DAT,
        S_DONE
    } state_t;

    localparam int ST_HI      = 31;
    localparam int ST_LO      = 30;
    localparam int OP_HI      = 29;
    localparam int OP_LO      = 28;
    localparam int HDR_BITS   = 14;
    localparam int TA_BITS    = 2;
    localparam int FRAME_BITS = 32;

    localparam logic [1:0] ST_C22 = 2'b01;
    localparam logic [1:0] ST_C45 = 2'b00;

    localparam logic [1:0] OP_C22_WR    = 2'b01;
    localparam logic [1:0] OP_C22_RD    = 2'b10;
    localparam logic [1:0] OP_C45_ADDR  = 2'b00;
    localparam logic [1:0] OP_C45_WR    = 2'b01;
    localparam logic [1:0] OP_C45_RDINC = 2'b10;
    localparam logic [1:0] OP_C45_RD    = 2'b11;

    // Anything that is not a recognised read is serialised as a write-type frame.
    function automatic logic is_read(input logic [1:0] st, input logic [1:0] op);
        logic rd;
        rd = 1'b0;
        if (st == ST_C22) begin
            case (op)
                OP_C22_RD: rd = 1'b1;
                OP_C22_WR: rd = 1'b0;
                default:   rd = 1'b0;
            endcase
        end else if (st == ST_C45) begin
            case (op)
                OP_C45_ADDR, OP_C45_WR:  rd = 1'b0;
                OP_C45_RD, OP_C45_RDINC: rd = 1'b1;
                default:                 rd = 1'b0;
            endcase
        end
        return rd;
    endfunction

endpackage

// File: rtl/mdio_clkgen.sv
// MDC generator: one bit period is 2*CLK_DIV clk cycles, low half first.
// Held parked (MDC low, counter at its terminal value) while run is low.
module mdio_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic mdc,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CW = ($clog2(2 * CLK_DIV) < 1) ? 1 : $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] CNT_RISE = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // Parking on the terminal count makes the first enabled edge start bit 0.
    assign rise_tick = run && (cnt == CNT_RISE);
    assign fall_tick = run && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst || !run) begin
            cnt <= CNT_LAST;
            mdc <= 1'b0;
        end else begin
            cnt <= fall_tick ? '0 : cnt + 1'b1;
            if (rise_tick)
                mdc <= 1'b1;
            else if (fall_tick)
                mdc <= 1'b0;
        end
    end

endmodule

// File: rtl/mdio_master.sv
// MDIO management station: serialises one 32-bit frame per request, with
// optional preamble, read turnaround check and a busy/done handshake.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int PRE_LEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MDIO_START,
    input  logic [31:0] T_DATA,
    input  logic        MDIO_IN,
    output logic [15:0] RD_DATA,
    output logic        DATA_RDY,
    output logic        RD_ERR,
    output logic        BUSY,
    output logic        MDC,
    output logic        MDIO_OE,
    output logic        MDIO_OUT
);

    localparam int TOTAL = PRE_LEN + FRAME_BITS;
    localparam int BW    = $clog2(TOTAL + 1);
    localparam logic [BW-1:0] B_HDR = BW'(PRE_LEN);
    localparam logic [BW-1:0] B_TA  = BW'(PRE_LEN + HDR_BITS);
    localparam logic [BW-1:0] B_DAT = BW'(PRE_LEN + HDR_BITS + TA_BITS);
    localparam logic [BW-1:0] B_END = BW'(TOTAL);

    state_t        state, next_state;
    logic [BW-1:0] bit_cnt;      // number of bits already started
    logic [31:0]   tx;
    logic [15:0]   rx;
    logic          rd_frame;
    logic          ta_err;
    logic          run;
    logic          rise_tick;
    logic          fall_tick;

    assign run      = state inside {S_PRE, S_HDR, S_TA, S_DAT};
    assign BUSY     = (state != S_IDLE);
    assign DATA_RDY = (state == S_DONE);

    mdio_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .mdc       (MDC),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // NOTE: next_state gets its default before the case so no path can infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: if (MDIO_START) next_state = (PRE_LEN > 0) ? S_PRE : S_HDR;
            S_DONE: next_state = S_IDLE;
            default: begin
                if (fall_tick) begin
                    if (bit_cnt == B_END)      next_state = S_DONE;
                    else if (bit_cnt >= B_DAT) next_state = S_DAT;
                    else if (bit_cnt >= B_TA)  next_state = S_TA;
                    else if (bit_cnt >= B_HDR) next_state = S_HDR;
                    else                       next_state = S_PRE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt  <= '0;
            tx       <= '0;
            rx       <= '0;
            rd_frame <= 1'b0;
            ta_err   <= 1'b0;
            RD_DATA  <= '0;
            RD_ERR   <= 1'b0;
            MDIO_OE  <= 1'b0;
            MDIO_OUT <= 1'b1;
        end else begin
            if (state == S_IDLE && MDIO_START) begin
                tx       <= T_DATA;
                rd_frame <= is_read(T_DATA[ST_HI:ST_LO], T_DATA[OP_HI:OP_LO]);
                bit_cnt  <= '0;
                ta_err   <= 1'b0;
                RD_ERR   <= 1'b0;
            end

            // During TA bit 1 the counter already points at the first data bit.
            if (rise_tick) begin
                if (state == S_TA && bit_cnt == B_DAT)
                    ta_err <= MDIO_IN;
                if (state == S_DAT)
                    rx <= {rx[14:0], MDIO_IN};
            end

            if (fall_tick) begin
                if (next_state == S_DONE) begin
                    MDIO_OE  <= 1'b0;
                    MDIO_OUT <= 1'b1;
                    if (rd_frame) begin
                        RD_DATA <= rx;
                        RD_ERR  <= ta_err;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                    if (next_state == S_PRE) begin
                        MDIO_OE  <= 1'b1;
                        MDIO_OUT <= 1'b1;
                    end else begin
                        MDIO_OUT <= tx[31];
                        tx       <= {tx[30:0], 1'b0};
                        MDIO_OE  <= !(rd_frame && next_state != S_HDR);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench: a CLK_DIV=2/PRE_LEN=0 instance for framing and read checks,
// and a default-parameter instance for preamble, ignored start and mid-frame reset.
module tb_mdio_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        a_start = 1'b0;
    logic [31:0] a_tdata = 32'h0;
    logic        a_in = 1'b1;
    logic [15:0] a_rd_data;
    logic        a_rdy, a_err, a_busy, a_mdc, a_oe, a_out;

    logic        b_start = 1'b0;
    logic [31:0] b_tdata = 32'h0;
    logic        b_in = 1'b1;
    logic [15:0] b_rd_data;
    logic        b_rdy, b_err, b_busy, b_mdc, b_oe, b_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mdio_master #(.CLK_DIV(2), .PRE_LEN(0)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .MDIO_START (a_start),
        .T_DATA     (a_tdata),
        .MDIO_IN    (a_in),
        .RD_DATA    (a_rd_data),
        .DATA_RDY   (a_rdy),
        .RD_ERR     (a_err),
        .BUSY       (a_busy),
        .MDC        (a_mdc),
        .MDIO_OE    (a_oe),
        .MDIO_OUT   (a_out)
    );

    mdio_master dut_b (
        .clk        (clk),
        .rst        (rst),
        .MDIO_START (b_start),
        .T_DATA     (b_tdata),
        .MDIO_IN    (b_in),
        .RD_DATA    (b_rd_data),
        .DATA_RDY   (b_rdy),
        .RD_ERR     (b_err),
        .BUSY       (b_busy),
        .MDC        (b_mdc),
        .MDIO_OE    (b_oe),
        .MDIO_OUT   (b_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One frame on instance A; the PHY model drives TA bit 1 and then phy MSB first.
    task automatic run_a(input string tag, input logic [31:0] frame, input logic rd,
                         input logic ta1, input logic [15:0] phy,
                         input logic [15:0] exp_rd, input logic exp_err);
        logic drive_oe;
        a_tdata = frame;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        a_tdata = 32'h0;
        check({tag, "_busy_acc"}, a_busy, 1);
        check({tag, "_err_clr"}, a_err, 0);
        for (int k = 0; k < 32; k++) begin
            tick();
            drive_oe = !(rd && k >= 14);
            check($sformatf("%s_mdc_lo%0d", tag, k), a_mdc, 0);
            check($sformatf("%s_oe%0d", tag, k), a_oe, drive_oe);
            if (drive_oe)
                check($sformatf("%s_out%0d", tag, k), a_out, frame[31-k]);
            if (k == 15)
                a_in = ta1;
            else if (k >= 16)
                a_in = phy[31-k];
            else
                a_in = 1'b1;
            tick(2);
            check($sformatf("%s_mdc_hi%0d", tag, k), a_mdc, 1);
            tick();
        end
        a_in = 1'b1;
        check({tag, "_rdy_early"}, a_rdy, 0);
        tick();
        check({tag, "_rdy"}, a_rdy, 1);
        check({tag, "_busy_done"}, a_busy, 1);
        check({tag, "_rd_data"}, a_rd_data, exp_rd);
        check({tag, "_rd_err"}, a_err, exp_err);
        check({tag, "_oe_done"}, a_oe, 0);
        check({tag, "_out_done"}, a_out, 1);
        check({tag, "_mdc_done"}, a_mdc, 0);
        tick();
        check({tag, "_rdy_pulse"}, a_rdy, 0);
        check({tag, "_busy_idle"}, a_busy, 0);
        check({tag, "_err_hold"}, a_err, exp_err);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] frame_b;
        int          rdy_at;

        // Reset held with start requests present on both instances.
        a_start = 1'b1;
        b_start = 1'b1;
        a_tdata = 32'h5A5AFF01;
        b_tdata = 32'h5A5AFF01;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_a_mdc", a_mdc, 0);
            check("rst_a_oe", a_oe, 0);
            check("rst_a_out", a_out, 1);
            check("rst_a_busy", a_busy, 0);
            check("rst_a_rdy", a_rdy, 0);
            check("rst_b_mdc", b_mdc, 0);
            check("rst_b_out", b_out, 1);
            check("rst_b_busy", b_busy, 0);
            check("rst_b_rdy", b_rdy, 0);
        end
        check("rst_a_rd_data", a_rd_data, 16'h0000);
        check("rst_a_rd_err", a_err, 0);
        a_start = 1'b0;
        b_start = 1'b0;
        rst = 1'b1;
        tick();
        check("idle_a_busy", a_busy, 0);

        // Instance A: C22 write, C22 read, TA error, C45 address, C45 read.
        run_a("c22_wr", 32'h5A5AFF01, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0);
        run_a("c22_rd", 32'h6A5A0000, 1'b1, 1'b0, 16'h8FF1, 16'h8FF1, 1'b0);
        run_a("ta_err", 32'h6A5A0000, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        run_a("c45_adr", 32'h0A5A1234, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
        run_a("c45_rd", 32'h3A5A0000, 1'b1, 1'b0, 16'hBEEF, 16'hBEEF, 1'b0);

        // Instance B: preamble, ignored second start, reset at bit 40.
        frame_b = 32'h5A5AFF01;
        b_tdata = frame_b;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        b_tdata = 32'h0;
        for (int k = 0; k < 40; k++) begin
            tick();
            check($sformatf("b_mdc%0d", k), b_mdc, 0);
            check($sformatf("b_oe%0d", k), b_oe, 1);
            if (k < 32)
                check($sformatf("b_pre%0d", k), b_out, 1);
            else
                check($sformatf("b_hdr%0d", k), b_out, frame_b[63-k]);
            if (k == 10) begin
                b_tdata = 32'hFFFFFFFF;
                b_start = 1'b1;
                tick();
                b_start = 1'b0;
                b_tdata = 32'h0;
                check("b_busy_ignore", b_busy, 1);
                tick(6);
            end else begin
                tick(7);
            end
        end
        tick();
        check("b_bit40_oe", b_oe, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("b_abort_mdc", b_mdc, 0);
        check("b_abort_oe", b_oe, 0);
        check("b_abort_out", b_out, 1);
        check("b_abort_busy", b_busy, 0);
        check("b_abort_rdy", b_rdy, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("b_abort_quiet", {b_rdy, b_busy, b_mdc}, 3'b000);
        end

        // Fresh C45 address frame completes at exactly t0+513.
        b_tdata = 32'h0A5A1234;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        rdy_at = -1;
        for (int n = 1; n <= 600; n++) begin
            tick();
            if (b_rdy === 1'b1 && rdy_at < 0)
                rdy_at = n;
            if (rdy_at >= 0)
                break;
        end
        check("b_rdy_cycle", rdy_at, 513);
        check("b_rd_err", b_err, 0);
        check("b_rd_data", b_rd_data, 16'h0000);
        tick();
        check("b_idle1", b_busy, 0);
        tick();
        check("b_idle2", b_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
